// File: rtl/mult_div_pkg.sv
// ============================================================
// mult_div_pkg: op encoding and FSM state type. Rev 1.0
// ============================================================
`default_nettype none

package mult_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'd0;
  localparam logic [1:0] OP_MULT  = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_DIV   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_step.sv
// ============================================================
// mult_div_step: one radix-2 multiply/divide iteration. Rev 1.0
// ============================================================
`default_nettype none

module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] w_x;
  logic [WIDTH:0] w_y;
  logic [WIDTH:0] w_sum;
  logic           w_cin;

  always_comb begin
    if (div_mode) begin
      w_x   = {acc, q[WIDTH-1]};
      w_y   = ~{1'b0, opnd};
      w_cin = 1'b1;
    end else begin
      w_x   = {1'b0, acc};
      w_y   = q[0] ? {1'b0, opnd} : '0;
      w_cin = 1'b0;
    end

    w_sum = w_x + w_y + {{WIDTH{1'b0}}, w_cin};

    // The partial remainder is always below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag for the restoring decision.
    if (div_mode) begin
      acc_next = w_sum[WIDTH] ? w_x[WIDTH-1:0] : w_sum[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], ~w_sum[WIDTH]};
    end else begin
      acc_next = w_sum[WIDTH:1];
      q_next   = {w_sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_seq.sv
// ============================================================
// mult_div_seq: sequential signed/unsigned multiply/divide. Rev 1.0
// ============================================================
`default_nettype none

module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dz;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_opnd;

  logic               w_is_div;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_q_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;

  assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (r_is_div),
    .acc      (r_acc),
    .q        (r_q),
    .opnd     (r_opnd),
    .acc_next (w_acc_next),
    .q_next   (w_q_next)
  );

  // Sign fixup: sign flags are only ever set for the signed ops.
  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_sign_a ^ r_sign_b) w_prod = -w_prod;
    w_quo = r_q;
    if (r_sign_a ^ r_sign_b) w_quo = -r_q;
    w_rem = r_acc;
    if (r_sign_a) w_rem = -r_acc;

    if (r_dz) begin
      w_hi = r_acc;
      w_lo = '1;
    end else if (r_is_div) begin
      w_hi = w_rem;
      w_lo = w_quo;
    end else begin
      w_hi = w_prod[2*WIDTH-1:WIDTH];
      w_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_is_div <= w_is_div;
              r_sign_a <= w_signed & a[WIDTH-1];
              r_sign_b <= w_signed & b[WIDTH-1];
              r_cnt    <= CNT_W'(WIDTH);
              busy     <= 1'b1;
              if (w_is_div && (b == '0)) begin
                // Divide by zero skips CALC; raw a is parked for hi.
                r_dz    <= 1'b1;
                r_acc   <= a;
                r_q     <= '0;
                r_opnd  <= '0;
                r_state <= S_FIXUP;
              end else begin
                r_dz    <= 1'b0;
                r_acc   <= '0;
                r_q     <= w_is_div ? w_mag_a : w_mag_b;
                r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIXUP;
          end
          S_FIXUP: begin
            hi       <= w_hi;
            lo       <= w_lo;
            div_zero <= r_dz;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
